fetch_queue: RTL

Decoupling instruction queue between the instruction ROM fetch stage and decode. Each cycle it accepts up to two fetched instructions (slot 0 at the fetch PC, slot 1 at the predicted-next PC) with their PCs and prediction bits. It presents up to two in-order entries per cycle to decode. It absorbs decode stalls and is emptied on a pipeline flush (branch mispredict or redirect).

---
 rtl/fetch_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: two-in / two-out circular instruction queue between fetch and decode.
// Entries hold instruction, PC and the slot-0 prediction bit; flush empties the queue.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_inst_0,
  input  logic [DATA_WIDTH-1:0] enq_inst_1,
  input  logic [ADDR_WIDTH-1:0] enq_pc_0,
  input  logic [ADDR_WIDTH-1:0] enq_pc_1,
  input  logic                  enq_pred_taken_0,
  output logic                  enq_ready,
  output logic [1:0]            deq_valid,
  output logic [DATA_WIDTH-1:0] deq_inst_0,
  output logic [DATA_WIDTH-1:0] deq_inst_1,
  output logic [ADDR_WIDTH-1:0] deq_pc_0,
  output logic [ADDR_WIDTH-1:0] deq_pc_1,
  output logic [1:0]            deq_pred_taken,
  input  logic                  deq_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] inst_q [DEPTH];
  logic [DATA_WIDTH-1:0] inst_d [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_d   [DEPTH];
  logic [DEPTH-1:0]      pred_q, pred_d;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_ready_q, enq_ready_d;
  logic [1:0]       n_enq, n_deq;

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  // Head window presented to decode; contents past count are don't-care.
  assign deq_valid      = {count_q >= CNT_W'(2), count_q != '0};
  assign deq_inst_0     = inst_q[head_q];
  assign deq_inst_1     = inst_q[head_p1];
  assign deq_pc_0       = pc_q[head_q];
  assign deq_pc_1       = pc_q[head_p1];
  assign deq_pred_taken = {pred_q[head_p1], pred_q[head_q]};
  assign enq_ready      = enq_ready_q;

  // Accepted enqueue/dequeue counts; flush suppresses both.
  always_comb begin
    n_enq = 2'd0;
    if (enq_ready_q && !flush && enq_valid[0]) begin
      n_enq = enq_valid[1] ? 2'd2 : 2'd1;
    end
    n_deq = 2'd0;
    if (deq_ready && !flush) begin
      n_deq = {1'b0, deq_valid[0]} + {1'b0, deq_valid[1]};
    end
  end

  // Next-state: entry writes, pointer/count advance, registered ready from post-update count.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    pred_d  = pred_q;
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
    if (n_enq != 2'd0) begin
      inst_d[tail_q] = enq_inst_0;
      pc_d[tail_q]   = enq_pc_0;
      pred_d[tail_q] = enq_pred_taken_0;
    end
    if (n_enq == 2'd2) begin
      inst_d[tail_p1] = enq_inst_1;
      pc_d[tail_p1]   = enq_pc_1;
      pred_d[tail_p1] = 1'b0;
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    enq_ready_d = (count_d <= CNT_W'(DEPTH - 2));
  end

  // State registers; reset also clears every stored field.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      pred_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      enq_ready_q <= 1'b1;
    end else begin
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      pred_q      <= pred_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      enq_ready_q <= enq_ready_d;
    end
  end

endmodule
